// File: rtl/boot_sequencer.sv
// Program loader and run controller: streams loader words into RAM, hands the bus
// to the CU, then supervises the run with halt detection and a timeout.
module boot_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned WR_HOLD = 2,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned MAX_RUN = 250000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              owns_bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write,
  output logic              ram_read,
  output logic              cpu_enable,
  input  logic              cpu_halt,
  output logic [CNT_W-1:0]  run_cycles,
  output logic [ADDR_W:0]   words_loaded,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned TMR_W = 16;
  localparam int unsigned WL_W  = ADDR_W + 1;
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(WR_HOLD - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] RUN_MAX     = CNT_W'(MAX_RUN);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_SETTLE, S_RUN, S_DONE, S_TIMEOUT
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WL_W-1:0]   words_q, words_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              ld_ready_q, ld_ready_d;
  logic              owns_bus_q, owns_bus_d;
  logic              ram_write_q, ram_write_d;
  logic              cpu_enable_q, cpu_enable_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      last_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      words_q      <= '0;
      run_q        <= '0;
      ld_ready_q   <= 1'b0;
      owns_bus_q   <= 1'b1;
      ram_write_q  <= 1'b0;
      cpu_enable_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      words_q      <= words_d;
      run_q        <= run_d;
      ld_ready_q   <= ld_ready_d;
      owns_bus_q   <= owns_bus_d;
      ram_write_q  <= ram_write_d;
      cpu_enable_q <= cpu_enable_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state and datapath; abort overrides every transition but leaves counters alone
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    words_d = words_q;
    run_d   = run_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start) begin
            state_d = S_LOAD;
            words_d = '0;
            run_d   = '0;
          end
        end
        S_LOAD: begin
          if (ld_valid && ld_ready_q) begin
            addr_d  = ld_addr;
            wdata_d = ld_data;
            last_d  = ld_last;
            words_d = words_q + WL_W'(1);
            tmr_d   = '0;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (tmr_q == HOLD_LAST) begin
            tmr_d = '0;
            if (!last_q)          state_d = S_LOAD;
            else if (SETTLE == 0) state_d = S_RUN;
            else                  state_d = S_SETTLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        S_SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            tmr_d   = '0;
            state_d = S_RUN;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        S_RUN: begin
          // The halting cycle still counts; halt beats a simultaneous timeout
          if (run_q != RUN_MAX) run_d = run_q + CNT_W'(1);
          if (cpu_halt)               state_d = S_DONE;
          else if (run_d == RUN_MAX)  state_d = S_TIMEOUT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the next state so they register alongside it
  always_comb begin
    ld_ready_d   = 1'b0;
    owns_bus_d   = 1'b1;
    ram_write_d  = 1'b0;
    cpu_enable_d = 1'b0;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    unique case (state_d)
      S_LOAD:    ld_ready_d  = 1'b1;
      S_WRITE:   ram_write_d = 1'b1;
      S_RUN: begin
        cpu_enable_d = 1'b1;
        owns_bus_d   = 1'b0;
      end
      S_DONE:    done_d      = 1'b1;
      S_TIMEOUT: timeout_d   = 1'b1;
      default: ;
    endcase
  end

  assign ld_ready     = ld_ready_q;
  assign owns_bus     = owns_bus_q;
  assign ram_addr     = addr_q;
  assign ram_wdata    = wdata_q;
  assign ram_write    = ram_write_q;
  assign ram_read     = 1'b0;
  assign cpu_enable   = cpu_enable_q;
  assign run_cycles   = run_q;
  assign words_loaded = words_q;
  assign done         = done_q;
  assign timeout      = timeout_q;

endmodule
